// File: rtl/i2c_seg_target.sv
// I2C write target holding NUM_REGS display registers; SCL/SDA are oversampled on clk_i.
// Optional read support is compiled in with `define I2C_TARGET_READ_EN.
module i2c_seg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h24,
  parameter int         NUM_REGS    = 4,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_pulse_o,
  output logic [7:0]            wr_idx_o,
  output logic                  busy_o
);
  localparam int               CNT_W      = $clog2(FILTER_LEN + 1);
  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]       NUM_REGS_9 = 9'(NUM_REGS);
  localparam logic [7:0]       LAST_PTR   = 8'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK,
    S_IGNORE, S_RDATA, S_RDATA_ACK
  } state_e;

  // Stage p0/p1: two-flop synchronizer, bit 0 = SCL, bit 1 = SDA
  logic [1:0]       line_p0_q, line_p1_q;
  // Stage p2: glitch filter and registered copy for edge detection
  logic [1:0]       filt_q, filt_d, prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_p0_q <= 2'b11;
      line_p1_q <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      line_p0_q <= {sda_i, scl_i};
      line_p1_q <= line_p0_q;
      filt_q    <= filt_d;
      prev_q    <= filt_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  // A change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (line_p1_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FILT_LAST) filt_d[i] = line_p1_q[i];
        else                       cnt_d[i]  = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic [6:0] shift_q;
  logic [7:0] ptr_q, ptr_nxt;

  assign scl_rise  =  filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] &  prev_q[0];
  assign start_det = ~filt_q[1] &  prev_q[1] & filt_q[0];
  assign stop_det  =  filt_q[1] & ~prev_q[1] & filt_q[0];
  assign byte_in   = {shift_q, filt_q[1]};
  assign ptr_nxt   = (ptr_q == LAST_PTR) ? 8'd0 : ptr_q + 8'd1;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic       sda_oe_q, wr_pulse_q, busy_q;
  logic [7:0] wr_idx_q;
  logic [7:0] regs_q [NUM_REGS];
`ifdef I2C_TARGET_READ_EN
  logic       rd_q;
  logic [7:0] rd_byte;
  assign rd_byte = regs_q[ptr_q[IDX_W-1:0]];
`endif

  // Stage p3: protocol FSM, all outputs registered
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      busy_q     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
`ifdef I2C_TARGET_READ_EN
      rd_q       <= 1'b0;
`endif
    end else begin
      wr_pulse_q <= 1'b0;
      if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
        rd_q      <= 1'b0;
`endif
      end else if (stop_det) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_REG, S_WDATA: begin
            if (scl_rise) begin
              shift_q   <= byte_in[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                case (state_q)
                  S_ADDR: begin
                    if (byte_in[7:1] == TARGET_ADDR && !byte_in[0]) begin
                      state_q <= S_ADDR_ACK;
                      busy_q  <= 1'b1;
                    end
`ifdef I2C_TARGET_READ_EN
                    else if (byte_in[7:1] == TARGET_ADDR) begin
                      state_q <= S_ADDR_ACK;
                      busy_q  <= 1'b1;
                      rd_q    <= 1'b1;
                    end
`endif
                    else state_q <= S_IGNORE;
                  end
                  S_REG: begin
                    if ({1'b0, byte_in} < NUM_REGS_9) begin
                      ptr_q   <= byte_in;
                      state_q <= S_REG_ACK;
                    end else begin
                      state_q <= S_IGNORE;
                    end
                  end
                  default: begin
                    regs_q[ptr_q[IDX_W-1:0]] <= byte_in;
                    wr_pulse_q <= 1'b1;
                    wr_idx_q   <= ptr_q;
                    ptr_q      <= ptr_nxt;
                    state_q    <= S_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // First SCL fall pulls SDA low, the next one releases it.
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                if (state_q == S_ADDR_ACK) begin
`ifdef I2C_TARGET_READ_EN
                  if (rd_q) begin
                    sda_oe_q  <= ~rd_byte[7];
                    bit_cnt_q <= 4'd1;
                    state_q   <= S_RDATA;
                  end else begin
                    state_q <= S_REG;
                  end
`else
                  state_q <= S_REG;
`endif
                end else begin
                  state_q <= S_WDATA;
                end
              end
            end
          end
`ifdef I2C_TARGET_READ_EN
          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RDATA_ACK;
              end else begin
                sda_oe_q  <= ~rd_byte[3'd7 - bit_cnt_q[2:0]];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!filt_q[1]) begin
                ptr_q     <= ptr_nxt;
                bit_cnt_q <= '0;
                state_q   <= S_RDATA;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) regs_o[k*8 +: 8] = regs_q[k];
  end

  assign sda_oe_o   = sda_oe_q;
  assign wr_pulse_o = wr_pulse_q;
  assign wr_idx_o   = wr_idx_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_seg_target.sv
// Bench for i2c_seg_target: transaction-level register model, open-drain bus, per-cycle compare.
module tb_i2c_seg_target;
  localparam int Q = 16;
  localparam int MS_IDLE = 0, MS_ADDR = 1, MS_REG = 2, MS_DATA = 3, MS_IGN = 4, MS_READ = 5;
`ifdef I2C_TARGET_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, scl_drv = 1'b1, sda_drv = 1'b1;
  logic        sda_bus, sda_oe, wr_pulse, busy;
  logic [31:0] regs;
  logic [7:0]  wr_idx;

  assign sda_bus = sda_drv & ~sda_oe;
  always #5 clk = ~clk;

  i2c_seg_target #(.TARGET_ADDR(7'h24), .NUM_REGS(4), .FILTER_LEN(3)) dut (
    .clk_i(clk), .reset_i(reset), .scl_i(scl_drv), .sda_i(sda_bus),
    .sda_oe_o(sda_oe), .regs_o(regs), .wr_pulse_o(wr_pulse), .wr_idx_o(wr_idx), .busy_o(busy)
  );

  typedef struct { logic [7:0] idx; logic [7:0] data; } wr_t;
  logic [7:0] exp_regs [4];
  wr_t        exp_wr [$];
  int         m_st = MS_IDLE, m_ptr = 0;
  logic       m_busy = 1'b0;
  bit         chk_en = 1'b0, allow_oe = 1'b0;
  int         n_chk = 0, n_fail = 0, pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_flat();
    return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
  endfunction

  always @(negedge clk) begin
    wr_t w;
    if (chk_en) begin
      check("regs", regs, exp_flat());
      check("busy", 32'(busy), 32'(m_busy));
    end
    check("sda_oe_outside_window", 32'(sda_oe & ~allow_oe), 32'd0);
    if (wr_pulse) begin
      pulse_cnt++;
      check("wr_pulse_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("wr_idx", 32'(wr_idx), 32'(w.idx));
        check("wr_data", 32'(regs[wr_idx*8 +: 8]), 32'(w.data));
      end
    end
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; qwait();
    scl_drv = 1'b1; qwait(); qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic i2c_start();
    chk_en = 1'b0;
    sda_drv = 1'b1; qwait();
    scl_drv = 1'b1; qwait();
    sda_drv = 1'b0; qwait();
    scl_drv = 1'b0; qwait();
    m_st = MS_ADDR; m_busy = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic i2c_stop();
    chk_en = 1'b0;
    sda_drv = 1'b0; qwait();
    scl_drv = 1'b1; qwait();
    sda_drv = 1'b1; qwait(); qwait();
    m_st = MS_IDLE; m_busy = 1'b0;
    chk_en = 1'b1;
  endtask

  // Controller writes one byte; the model decides ack and register effect from the protocol rules.
  task automatic ctl_byte(input logic [7:0] b);
    logic exp_ack, got;
    chk_en = 1'b0;
    exp_ack = 1'b0;
    case (m_st)
      MS_ADDR: begin
        if (b[7:1] == 7'h24 && (!b[0] || READ_EN)) begin
          exp_ack = 1'b1; m_busy = 1'b1;
          m_st = b[0] ? MS_READ : MS_REG;
        end else m_st = MS_IGN;
      end
      MS_REG: begin
        if (b < 8'd4) begin exp_ack = 1'b1; m_ptr = int'(b); m_st = MS_DATA; end
        else m_st = MS_IGN;
      end
      MS_DATA: begin
        exp_ack = 1'b1;
        exp_wr.push_back('{idx: 8'(m_ptr), data: b});
        exp_regs[m_ptr] = b;
        m_ptr = (m_ptr + 1) % 4;
      end
      default: ;
    endcase
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) allow_oe = exp_ack;
      send_bit(b[i]);
    end
    sda_drv = 1'b1; qwait();
    scl_drv = 1'b1; qwait();
    got = sda_bus; qwait();
    scl_drv = 1'b0; qwait();
    allow_oe = 1'b0;
    check($sformatf("ack_%02h", b), 32'(got), 32'(!exp_ack));
    chk_en = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    chk_en = 1'b0;
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

`ifdef I2C_TARGET_READ_EN
  task automatic rd_byte(input logic ack);
    logic [7:0] got, expb;
    chk_en = 1'b0; allow_oe = 1'b1;
    expb = exp_regs[m_ptr];
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      got[i] = sda_bus; qwait();
      scl_drv = 1'b0; qwait();
    end
    check("rd_byte", 32'(got), 32'(expb));
    send_bit(!ack);
    if (ack) m_ptr = (m_ptr + 1) % 4;
    else begin allow_oe = 1'b0; m_st = MS_IGN; end
    chk_en = 1'b1;
  endtask
`endif

  initial begin
    int p0;
    for (int k = 0; k < 4; k++) exp_regs[k] = 8'h00;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    qwait();
    check("rst_regs", regs, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk_en = 1'b1;

    // Plain write with pointer 1
    p0 = pulse_cnt;
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h01); ctl_byte(8'hA5); ctl_byte(8'h3C); i2c_stop();
    check("t1_regs", regs, 32'h003CA500);
    check("t1_pulses", 32'(pulse_cnt - p0), 32'd2);

    // Wrong address
    p0 = pulse_cnt;
    i2c_start(); ctl_byte(8'h4A); ctl_byte(8'h12); ctl_byte(8'h34);
    check("t2_busy", 32'(busy), 32'd0);
    i2c_stop();
    check("t2_regs", regs, 32'h003CA500);
    check("t2_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Pointer wrap 3 -> 0
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h03); ctl_byte(8'h11); ctl_byte(8'h22); i2c_stop();
    check("t3_regs", regs, 32'h113CA522);

    // Out-of-range pointer
    p0 = pulse_cnt;
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h07); ctl_byte(8'h55); ctl_byte(8'h66);
    check("t4_busy", 32'(busy), 32'd1);
    i2c_stop();
    check("t4_regs", regs, 32'h113CA522);
    check("t4_pulses", 32'(pulse_cnt - p0), 32'd0);

    // STOP after a partial data byte
    p0 = pulse_cnt;
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h00); send_bits(8'hFF, 4); i2c_stop();
    check("t5_stop_regs", regs, 32'h113CA522);
    check("t5_stop_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Reset in the middle of a data byte
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h01); send_bits(8'hF0, 4);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    check("t5_rst_regs", regs, 32'h0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_sda_oe", 32'(sda_oe), 32'd0);
    for (int k = 0; k < 4; k++) exp_regs[k] = 8'h00;
    m_st = MS_IDLE; m_busy = 1'b0; m_ptr = 0;
    i2c_stop();
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h02); ctl_byte(8'h77); i2c_stop();
    check("t5_after_regs", regs, 32'h00770000);

    // Read attempt after setting pointer 0
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h00); ctl_byte(8'hC3); ctl_byte(8'h5A); i2c_stop();
    check("t6_regs", regs, 32'h00775AC3);
    i2c_start(); ctl_byte(8'h48); ctl_byte(8'h00);
    i2c_start(); ctl_byte(8'h49);
`ifdef I2C_TARGET_READ_EN
    rd_byte(1'b1);
    rd_byte(1'b0);
`else
    check("t6_busy_nack", 32'(busy), 32'd0);
`endif
    i2c_stop();
    check("t6_final_regs", regs, 32'h00775AC3);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
